// File: rtl/ddr_cmd_responder.sv
// rtl/ddr_cmd_responder.sv - DDR4 command-bus responder with per-bank timing checks
// Decodes pin-level commands, tracks bank state and forwards legal RD/WR.
module ddr_cmd_responder #(
  parameter int NUMBER_BANK = 16,
  parameter int RA_WIDTH    = 17,
  parameter int CA_WIDTH    = 10,
  parameter int CNT_WIDTH   = 8,
  parameter int tRCD        = 16,
  parameter int tRAS        = 39,
  parameter int tRP         = 16
) (
  input  logic                   clock_t,
  input  logic                   reset,
  input  logic                   cs_n,
  input  logic                   act_n,
  input  logic                   ras_n,
  input  logic                   cas_n,
  input  logic                   we_n,
  input  logic [1:0]             bg,
  input  logic [1:0]             ba,
  input  logic [13:0]            addr,
  input  logic                   err_clear,
  output logic [NUMBER_BANK-1:0] bank_open,
  output logic                   cas_valid,
  output logic                   cas_write,
  output logic [3:0]             cas_bank,
  output logic [RA_WIDTH-1:0]    cas_row,
  output logic [CA_WIDTH-1:0]    cas_col,
  output logic [4:0]             err_flags,
  output logic                   err_pulse
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_PRECH} bank_state_e;
  typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_PRE, CMD_PREA, CMD_RD, CMD_WR, CMD_REF} cmd_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] T_RCD   = CNT_WIDTH'(tRCD);
  localparam logic [CNT_WIDTH-1:0] T_RAS   = CNT_WIDTH'(tRAS);
  localparam logic [CNT_WIDTH-1:0] T_RP    = CNT_WIDTH'(tRP);

  bank_state_e             state_q [NUMBER_BANK];
  bank_state_e             state_d [NUMBER_BANK];
  logic [CNT_WIDTH-1:0]    cnt_q   [NUMBER_BANK];
  logic [CNT_WIDTH-1:0]    cnt_d   [NUMBER_BANK];
  logic [RA_WIDTH-1:0]     row_q   [NUMBER_BANK];
  logic [RA_WIDTH-1:0]     row_d   [NUMBER_BANK];

  logic [NUMBER_BANK-1:0]  bank_open_q, bank_open_d;
  logic                    cas_valid_q, cas_valid_d;
  logic                    cas_write_q, cas_write_d;
  logic [3:0]              cas_bank_q, cas_bank_d;
  logic [RA_WIDTH-1:0]     cas_row_q, cas_row_d;
  logic [CA_WIDTH-1:0]     cas_col_q, cas_col_d;
  logic [4:0]              err_flags_q, err_flags_d;
  logic                    err_pulse_q, err_pulse_d;

  cmd_e                    cmd;
  logic [3:0]              cmd_bank;
  logic [RA_WIDTH-1:0]     act_row;
  logic [4:0]              err_new;
  logic                    any_active_early;
  logic                    any_busy;

  assign cmd_bank = {bg, ba};
  assign act_row  = RA_WIDTH'({ras_n, cas_n, we_n, addr});

  always_comb begin
    cmd = CMD_NOP;
    if (!cs_n) begin
      if (!act_n) begin
        cmd = CMD_ACT;
      end else begin
        case ({ras_n, cas_n, we_n})
          3'b010:  cmd = addr[10] ? CMD_PREA : CMD_PRE;
          3'b101:  cmd = CMD_RD;
          3'b100:  cmd = CMD_WR;
          3'b001:  cmd = CMD_REF;
          default: cmd = CMD_NOP;
        endcase
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    row_d            = row_q;
    err_new          = '0;
    cas_valid_d      = 1'b0;
    cas_write_d      = cas_write_q;
    cas_bank_d       = cas_bank_q;
    cas_row_d        = cas_row_q;
    cas_col_d        = cas_col_q;
    any_active_early = 1'b0;
    any_busy         = 1'b0;
    bank_open_d      = '0;

    // Background aging; a precharging bank past tRP counts as idle this cycle.
    for (int i = 0; i < NUMBER_BANK; i++) begin
      if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
      if (state_q[i] == ST_PRECH && cnt_q[i] >= T_RP) state_d[i] = ST_IDLE;
      if (state_q[i] == ST_ACTIVE && cnt_q[i] < T_RAS) any_active_early = 1'b1;
      if (state_q[i] == ST_ACTIVE || (state_q[i] == ST_PRECH && cnt_q[i] < T_RP)) any_busy = 1'b1;
    end

    case (cmd)
      CMD_ACT: begin
        if (state_q[cmd_bank] == ST_ACTIVE) begin
          err_new[0] = 1'b1;
        end else if (state_q[cmd_bank] == ST_PRECH && cnt_q[cmd_bank] < T_RP) begin
          err_new[1] = 1'b1;
        end else begin
          state_d[cmd_bank] = ST_ACTIVE;
          cnt_d[cmd_bank]   = CNT_ONE;
          row_d[cmd_bank]   = act_row;
        end
      end
      CMD_RD, CMD_WR: begin
        if (state_q[cmd_bank] == ST_ACTIVE && cnt_q[cmd_bank] >= T_RCD) begin
          cas_valid_d = 1'b1;
          cas_write_d = (cmd == CMD_WR);
          cas_bank_d  = cmd_bank;
          cas_row_d   = row_q[cmd_bank];
          cas_col_d   = addr[CA_WIDTH-1:0];
        end else begin
          err_new[2] = 1'b1;
        end
      end
      CMD_PRE: begin
        if (state_q[cmd_bank] == ST_ACTIVE) begin
          if (cnt_q[cmd_bank] >= T_RAS) begin
            state_d[cmd_bank] = ST_PRECH;
            cnt_d[cmd_bank]   = CNT_ONE;
          end else begin
            err_new[3] = 1'b1;
          end
        end
      end
      CMD_PREA: begin
        if (any_active_early) begin
          err_new[3] = 1'b1;
        end else begin
          for (int i = 0; i < NUMBER_BANK; i++) begin
            if (state_q[i] == ST_ACTIVE) begin
              state_d[i] = ST_PRECH;
              cnt_d[i]   = CNT_ONE;
            end
          end
        end
      end
      CMD_REF: begin
        if (any_busy) err_new[4] = 1'b1;
      end
      default: ;
    endcase

    err_flags_d = (err_clear ? 5'b0 : err_flags_q) | err_new;
    err_pulse_d = |err_new;
    for (int i = 0; i < NUMBER_BANK; i++) begin
      bank_open_d[i] = (state_d[i] == ST_ACTIVE);
    end
  end

  always_ff @(posedge clock_t) begin
    if (reset) begin
      for (int i = 0; i < NUMBER_BANK; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= CNT_MAX;
        row_q[i]   <= '0;
      end
      bank_open_q <= '0;
      cas_valid_q <= 1'b0;
      cas_write_q <= 1'b0;
      cas_bank_q  <= '0;
      cas_row_q   <= '0;
      cas_col_q   <= '0;
      err_flags_q <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      bank_open_q <= bank_open_d;
      cas_valid_q <= cas_valid_d;
      cas_write_q <= cas_write_d;
      cas_bank_q  <= cas_bank_d;
      cas_row_q   <= cas_row_d;
      cas_col_q   <= cas_col_d;
      err_flags_q <= err_flags_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign bank_open = bank_open_q;
  assign cas_valid = cas_valid_q;
  assign cas_write = cas_write_q;
  assign cas_bank  = cas_bank_q;
  assign cas_row   = cas_row_q;
  assign cas_col   = cas_col_q;
  assign err_flags = err_flags_q;
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_ddr_cmd_responder.sv
// tb/tb_ddr_cmd_responder.sv - directed vector bench for ddr_cmd_responder
module tb_ddr_cmd_responder;

  localparam int C_NOP = 0, C_ACT = 1, C_PRE = 2, C_PREA = 3, C_RD = 4, C_WR = 5, C_REF = 6;

  logic        clock_t = 1'b0;
  logic        reset;
  logic        cs_n, act_n, ras_n, cas_n, we_n;
  logic [1:0]  bg, ba;
  logic [13:0] addr;
  logic        err_clear;
  logic [15:0] bank_open;
  logic        cas_valid, cas_write;
  logic [3:0]  cas_bank;
  logic [16:0] cas_row;
  logic [9:0]  cas_col;
  logic [4:0]  err_flags;
  logic        err_pulse;

  int checks = 0;
  int errors = 0;

  ddr_cmd_responder dut (
    .clock_t(clock_t), .reset(reset), .cs_n(cs_n), .act_n(act_n),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .bg(bg), .ba(ba),
    .addr(addr), .err_clear(err_clear), .bank_open(bank_open),
    .cas_valid(cas_valid), .cas_write(cas_write), .cas_bank(cas_bank),
    .cas_row(cas_row), .cas_col(cas_col), .err_flags(err_flags),
    .err_pulse(err_pulse)
  );

  always #5 clock_t = ~clock_t;

  typedef struct {
    int          gap;
    int          cmd;
    logic        desel;
    logic [3:0]  bank;
    logic [16:0] row;
    logic [9:0]  col;
    logic        clr;
    logic [15:0] e_open;
    logic        e_cv;
    logic        e_wr;
    logic [16:0] e_row;
    logic [4:0]  e_err;
    logic        e_pulse;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int gap, int cmd, logic desel, logic [3:0] bank,
                              logic [16:0] row, logic [9:0] col, logic clr,
                              logic [15:0] e_open, logic e_cv, logic e_wr,
                              logic [16:0] e_row, logic [4:0] e_err, logic e_pulse);
    vec_t v;
    v.gap = gap; v.cmd = cmd; v.desel = desel; v.bank = bank; v.row = row;
    v.col = col; v.clr = clr; v.e_open = e_open; v.e_cv = e_cv; v.e_wr = e_wr;
    v.e_row = e_row; v.e_err = e_err; v.e_pulse = e_pulse;
    return v;
  endfunction

  task automatic drive(int cmd, logic desel, logic [3:0] bank, logic [16:0] row,
                       logic [9:0] col, logic clr);
    cs_n = desel ? 1'b1 : (cmd == C_NOP);
    act_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    addr = '0;
    {bg, ba} = bank;
    err_clear = clr;
    case (cmd)
      C_ACT:  begin act_n = 1'b0; {ras_n, cas_n, we_n, addr} = row; end
      C_PRE:  begin {ras_n, cas_n, we_n} = 3'b010; addr[10] = 1'b0; end
      C_PREA: begin {ras_n, cas_n, we_n} = 3'b010; addr[10] = 1'b1; end
      C_RD:   begin {ras_n, cas_n, we_n} = 3'b101; addr[9:0] = col; end
      C_WR:   begin {ras_n, cas_n, we_n} = 3'b100; addr[9:0] = col; end
      C_REF:  begin {ras_n, cas_n, we_n} = 3'b001; end
      default: ;
    endcase
  endtask

  task automatic step(int cmd, logic desel, logic [3:0] bank, logic [16:0] row,
                      logic [9:0] col, logic clr);
    @(negedge clock_t);
    drive(cmd, desel, bank, row, col, clr);
    @(posedge clock_t);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    vecs.push_back(mk( 0, C_ACT,  0, 4'd5, 17'h1ABCD, 10'h000, 0, 16'h0020, 0, 0, 17'h0,     5'h00, 0));
    vecs.push_back(mk(15, C_RD,   0, 4'd5, 17'h0,     10'h040, 0, 16'h0020, 1, 0, 17'h1ABCD, 5'h00, 0));
    vecs.push_back(mk( 0, C_NOP,  0, 4'd0, 17'h0,     10'h000, 0, 16'h0020, 0, 0, 17'h0,     5'h00, 0));
    vecs.push_back(mk( 0, C_ACT,  0, 4'd2, 17'h00123, 10'h000, 0, 16'h0024, 0, 0, 17'h0,     5'h00, 0));
    vecs.push_back(mk(14, C_WR,   0, 4'd2, 17'h0,     10'h155, 0, 16'h0024, 0, 0, 17'h0,     5'h04, 1));
    vecs.push_back(mk( 0, C_WR,   0, 4'd2, 17'h0,     10'h155, 0, 16'h0024, 1, 1, 17'h00123, 5'h04, 0));
    vecs.push_back(mk( 0, C_NOP,  0, 4'd0, 17'h0,     10'h000, 1, 16'h0024, 0, 0, 17'h0,     5'h00, 0));
    vecs.push_back(mk( 0, C_ACT,  0, 4'd0, 17'h1FFFF, 10'h000, 0, 16'h0025, 0, 0, 17'h0,     5'h00, 0));
    vecs.push_back(mk(37, C_PRE,  0, 4'd0, 17'h0,     10'h000, 0, 16'h0025, 0, 0, 17'h0,     5'h08, 1));
    vecs.push_back(mk( 0, C_PRE,  0, 4'd0, 17'h0,     10'h000, 0, 16'h0024, 0, 0, 17'h0,     5'h08, 0));
    vecs.push_back(mk(14, C_ACT,  0, 4'd0, 17'h00001, 10'h000, 0, 16'h0024, 0, 0, 17'h0,     5'h0A, 1));
    vecs.push_back(mk( 0, C_ACT,  0, 4'd0, 17'h00001, 10'h000, 0, 16'h0025, 0, 0, 17'h0,     5'h0A, 0));
    vecs.push_back(mk( 0, C_ACT,  1, 4'd4, 17'h00077, 10'h000, 1, 16'h0025, 0, 0, 17'h0,     5'h00, 0));
    vecs.push_back(mk( 0, C_ACT,  0, 4'd1, 17'h0AAAA, 10'h000, 0, 16'h0027, 0, 0, 17'h0,     5'h00, 0));
    vecs.push_back(mk( 0, C_ACT,  0, 4'd9, 17'h15555, 10'h000, 0, 16'h0227, 0, 0, 17'h0,     5'h00, 0));
    vecs.push_back(mk(58, C_PREA, 0, 4'd0, 17'h0,     10'h000, 0, 16'h0000, 0, 0, 17'h0,     5'h00, 0));
    vecs.push_back(mk(15, C_REF,  0, 4'd0, 17'h0,     10'h000, 0, 16'h0000, 0, 0, 17'h0,     5'h00, 0));
    vecs.push_back(mk( 0, C_ACT,  0, 4'd1, 17'h00042, 10'h000, 0, 16'h0002, 0, 0, 17'h0,     5'h00, 0));
    vecs.push_back(mk( 0, C_PREA, 0, 4'd0, 17'h0,     10'h000, 0, 16'h0002, 0, 0, 17'h0,     5'h08, 1));
    vecs.push_back(mk( 0, C_REF,  0, 4'd0, 17'h0,     10'h000, 0, 16'h0002, 0, 0, 17'h0,     5'h18, 1));
    vecs.push_back(mk( 0, C_ACT,  0, 4'd1, 17'h00099, 10'h000, 1, 16'h0002, 0, 0, 17'h0,     5'h01, 1));
    vecs.push_back(mk( 0, C_RD,   0, 4'd3, 17'h0,     10'h000, 0, 16'h0002, 0, 0, 17'h0,     5'h05, 1));
    vecs.push_back(mk(13, C_RD,   0, 4'd1, 17'h0,     10'h3FF, 0, 16'h0002, 1, 0, 17'h00042, 5'h05, 0));

    reset = 1'b1;
    drive(C_NOP, 0, 4'd0, 17'h0, 10'h0, 0);
    step(C_NOP, 0, 4'd0, 17'h0, 10'h0, 0);
    step(C_NOP, 0, 4'd0, 17'h0, 10'h0, 0);
    check("rst_open", 32'(bank_open), 32'h0);
    check("rst_cv", 32'(cas_valid), 32'h0);
    check("rst_err", 32'(err_flags), 32'h0);
    check("rst_pulse", 32'(err_pulse), 32'h0);
    @(negedge clock_t);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      for (int g = 0; g < vecs[i].gap; g++) step(C_NOP, 0, 4'd0, 17'h0, 10'h0, 0);
      step(vecs[i].cmd, vecs[i].desel, vecs[i].bank, vecs[i].row, vecs[i].col, vecs[i].clr);
      check($sformatf("v%0d_open", i), 32'(bank_open), 32'(vecs[i].e_open));
      check($sformatf("v%0d_cv", i), 32'(cas_valid), 32'(vecs[i].e_cv));
      check($sformatf("v%0d_err", i), 32'(err_flags), 32'(vecs[i].e_err));
      check($sformatf("v%0d_pulse", i), 32'(err_pulse), 32'(vecs[i].e_pulse));
      if (vecs[i].e_cv) begin
        check($sformatf("v%0d_wr", i), 32'(cas_write), 32'(vecs[i].e_wr));
        check($sformatf("v%0d_bank", i), 32'(cas_bank), 32'(vecs[i].bank));
        check($sformatf("v%0d_row", i), 32'(cas_row), 32'(vecs[i].e_row));
        check($sformatf("v%0d_col", i), 32'(cas_col), 32'(vecs[i].col));
      end
    end

    // Reset in the middle of traffic: bank 1 open, CAS pulse just issued.
    @(negedge clock_t);
    reset = 1'b1;
    drive(C_ACT, 0, 4'd7, 17'h00321, 10'h0, 0);
    @(posedge clock_t);
    #1;
    check("mid_rst_open", 32'(bank_open), 32'h0);
    check("mid_rst_cv", 32'(cas_valid), 32'h0);
    check("mid_rst_err", 32'(err_flags), 32'h0);
    check("mid_rst_bank", 32'(cas_bank), 32'h0);
    check("mid_rst_row", 32'(cas_row), 32'h0);
    check("mid_rst_col", 32'(cas_col), 32'h0);
    @(negedge clock_t);
    reset = 1'b0;
    step(C_RD, 0, 4'd1, 17'h0, 10'h010, 0);
    check("post_rst_rd_cv", 32'(cas_valid), 32'h0);
    check("post_rst_rd_err", 32'(err_flags), 32'h04);
    check("post_rst_rd_pulse", 32'(err_pulse), 32'h1);
    step(C_NOP, 0, 4'd0, 17'h0, 10'h0, 0);
    check("pulse_one_cycle", 32'(err_pulse), 32'h0);
    check("flag_sticky", 32'(err_flags), 32'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_cmd_responder.md
Name: ddr_cmd_responder

Overview:
Memory-side responder for the DDR4 command bus driven by the controller's ACT/PRE/CAS sequencers. It decodes ACT, PRE, PREA, RD, WR and REF from the pin-level command signals. It tracks per-bank open-row state and elapsed-cycle counters, and checks tRCD/tRAS/tRP legality. Accepted column commands are forwarded to the data-path model; protocol violations are flagged.

Parameters:
NUMBER_BANK, 16, banks addressed as {bg,ba}
RA_WIDTH, 17, row address width
CA_WIDTH, 10, column address width
CNT_WIDTH, 8, per-bank elapsed counter width, saturating
tRCD, 16, minimum cycles ACT to RD/WR on the same bank
tRAS, 39, minimum cycles ACT to PRE on the same bank
tRP, 16, minimum cycles PRE to ACT on the same bank

Ports:
clock_t  input  1  command clock (ck_t)
reset  input  1  synchronous, active-high reset
cs_n  input  1  chip select, command valid when 0
act_n  input  1  activate, low = ACT
ras_n  input  1  RAS_n / A16
cas_n  input  1  CAS_n / A15
we_n  input  1  WE_n / A14
bg  input  2  bank group
ba  input  2  bank address
addr  input  14  A13..A0 (A10 = AP on PRE)
err_clear  input  1  clears sticky error bits
bank_open  output  NUMBER_BANK  1 = bank in ACTIVE state
cas_valid  output  1  one-cycle pulse, accepted RD/WR
cas_write  output  1  1 = WR, 0 = RD (valid with cas_valid)
cas_bank  output  4  {bg,ba} of accepted CAS
cas_row  output  RA_WIDTH  open row of that bank
cas_col  output  CA_WIDTH  addr[9:0] of CAS
err_flags  output  5  sticky: [0] act_open, [1] act_early, [2] cas_illegal, [3] pre_early, [4] ref_open
err_pulse  output  1  one-cycle pulse on any new violation

Behaviour:
- All state is updated on the posedge of clock_t. While reset is high: all banks IDLE, counters saturated (all ones), and all outputs 0. Reset mid-operation discards open rows at the next edge.
- Decode applies only when cs_n=0; otherwise the cycle is NOP.
  - act_n=0: ACT, row = {ras_n,cas_n,we_n,addr}.
  - act_n=1 with ras/cas/we = L,H,L: PRE (addr[10]=0) or PREA (addr[10]=1).
  - H,L,H: RD. H,L,L: WR. L,L,H: REF. Any other combination: NOP.
- Per-bank state: IDLE, ACTIVE, PRECHARGING. Each bank has a counter cnt, loaded with 1 on an applied ACT or PRE to that bank, otherwise incremented each cycle and saturating at 2^CNT_WIDTH-1. A command exactly d cycles after ACT/PRE sees cnt=d.
- PRECHARGING moves to IDLE on the first cycle where cnt>=tRP.
- ACT:
  - Legal in IDLE, or in PRECHARGING with cnt>=tRP. Stores the row, sets state ACTIVE.
  - ACT to an ACTIVE bank raises err act_open.
  - ACT to a PRECHARGING bank with cnt<tRP raises err act_early.
- RD/WR: legal only if the bank is ACTIVE and cnt>=tRCD. Then cas_valid=1 on the following cycle, with cas_write/bank/row/col registered from the command edge. Otherwise raise cas_illegal and do not pulse cas_valid.
- PRE:
  - To an IDLE or PRECHARGING bank: legal no-op, counter untouched.
  - To an ACTIVE bank with cnt>=tRAS: state becomes PRECHARGING.
  - To an ACTIVE bank with cnt<tRAS: raises pre_early.
- PREA: if any ACTIVE bank has cnt<tRAS, raise pre_early and apply PREA to no bank. Otherwise every ACTIVE bank becomes PRECHARGING.
- REF: legal only if all banks are IDLE; otherwise raise ref_open. Legal REF has no state effect.
- Every erroring command is ignored: no bank state or counter change.
- Outputs bank_open, err_flags and err_pulse are registered, one cycle after the command edge.
- err_flags bits are sticky. err_clear clears all bits; if a new error occurs in the same cycle as err_clear, that error's bit is set (set wins).
- Only one command per cycle exists on the bus, so there are no intra-cycle command conflicts.

Test Plan:
- Reset, then ACT bank 5 row 0x1ABCD at cycle 0; RD col 0x040 at cycle 16 -> bank_open[5]=1 from cycle 1; cas_valid at cycle 17 with cas_bank=5, cas_row=0x1ABCD, cas_col=0x040, cas_write=0.
- ACT bank 2 at cycle 0; WR at cycle 15 -> no cas_valid; err_flags[2]=1 and err_pulse at cycle 16. WR at cycle 16 -> cas_valid, cas_write=1.
- ACT bank 0 at cycle 0; PRE at 38 -> pre_early, bank stays open. PRE at 39 -> bank_open[0]=0. ACT at 54 -> act_early. ACT at 55 -> accepted.
- ACT on banks 1 and 9, then PREA at cycle 60 -> both close. REF at 76 -> no error. REF issued with bank 1 still open -> err_flags[4].
- Hold error flags set, assert err_clear together with a new ACT to an open bank -> err_flags=5'b00001 next cycle. Assert reset mid-burst -> all outputs 0, bank_open=0.
